// File: rtl/result_drain.sv
// result_drain
// Captures the four accumulator results of the 2x2 PE array on the feeder's
// push11 / pushedge / push22 pulses. Whole 2x2 tiles are buffered, then
// streamed out one word at a time over a valid/ready handshake. done pulses
// once every tile of a size x size product has been delivered.
//
// Optional feature macro: RESULT_DRAIN_ERR_EN
//   defined   : err is a sticky flag for dropped tiles, push-order violations
//               and more tiles than expected
//   undefined : err is tied 0 and no sequence tracking is built
//
// Parameters
//   TILE_DEPTH : number of buffered result tiles (power of two, >= 2)
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   start, size            : job start pulse and matrix dimension (signed)
//   push11/pushedge/push22 : capture strobes from the operand feeder
//   c11, c12, c21, c22     : PE accumulator outputs
//   out_data/out_valid     : result word stream to the consumer
//   out_ready              : consumer accepts a word when high with out_valid
//   busy, done, err        : job in progress, completion pulse, error flag
module result_drain #(
    parameter int TILE_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic signed [16:0] size,
    input  logic               push11,
    input  logic               pushedge,
    input  logic               push22,
    input  logic signed [31:0] c11,
    input  logic signed [31:0] c12,
    input  logic signed [31:0] c21,
    input  logic signed [31:0] c22,
    output logic        [31:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int PW = (TILE_DEPTH > 1) ? $clog2(TILE_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(TILE_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t            state_reg;
    // Packed index 3 holds c11, index 0 holds c22.
    logic [3:0][31:0]  tile_mem [TILE_DEPTH];
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;      // tiles held, including the one being emitted
    logic [1:0]        word_idx_reg;   // word of the head tile currently on out_data
    logic [31:0]       expected_reg;
    logic [31:0]       tiles_in_reg;
    logic [31:0]       stage_c11_reg;
    logic [31:0]       stage_c12_reg;
    logic [31:0]       stage_c21_reg;

    logic              start_accept;
    logic              take11, take_edge, take22;
    logic [31:0]       tile_c11, tile_c12, tile_c21;
    logic              fire, pop_last, has_slot, commit;
    logic [CW-1:0]     count_next, queued;
    logic [PW-1:0]     head_ptr;
    logic [31:0]       tiles_in_next;
    logic [31:0]       next_word;
    logic              load_word;
    logic signed [16:0] half_size;
    logic [31:0]       half_ext;
    logic [31:0]       expected_calc;

    always_comb begin
        start_accept = (state_reg == IDLE) && start;
        take11       = (state_reg == RUN) && push11;
        take_edge    = (state_reg == RUN) && pushedge;
        take22       = (state_reg == RUN) && push22;

        // Same-cycle strobes forward straight into the committed tile.
        tile_c11 = take11    ? c11 : stage_c11_reg;
        tile_c12 = take_edge ? c12 : stage_c12_reg;
        tile_c21 = take_edge ? c21 : stage_c21_reg;

        fire     = out_valid && out_ready;
        pop_last = fire && (word_idx_reg == 2'd3);
        // A slot freed by this edge's c22 pop is reusable on the same edge.
        has_slot = (count_reg != DEPTH_C) || pop_last;
        commit   = take22 && has_slot;

        count_next    = count_reg + {{(CW-1){1'b0}}, commit} - {{(CW-1){1'b0}}, pop_last};
        queued        = count_reg - {{(CW-1){1'b0}}, pop_last};
        head_ptr      = pop_last ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
        tiles_in_next = tiles_in_reg + {31'b0, take22};

        // Next word: following word of the head tile, else c11 of the next
        // buffered tile, else c11 of the tile being committed right now.
        if (fire && (word_idx_reg != 2'd3)) begin
            next_word = tile_mem[rd_ptr_reg][2'd2 - word_idx_reg];
        end else if (queued != '0) begin
            next_word = tile_mem[head_ptr][3];
        end else begin
            next_word = tile_c11;
        end
        load_word = (fire || !out_valid) && (count_next != '0);

        half_size     = size / 17'sd2;
        half_ext      = {15'b0, half_size};
        expected_calc = (size < 17'sd2) ? 32'd0 : half_ext * half_ext;
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            tile_mem[wr_ptr_reg] <= {tile_c11, tile_c12, tile_c21, c22};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            word_idx_reg  <= '0;
            expected_reg  <= '0;
            tiles_in_reg  <= '0;
            stage_c11_reg <= '0;
            stage_c12_reg <= '0;
            stage_c21_reg <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        expected_reg  <= expected_calc;
                        tiles_in_reg  <= '0;
                        stage_c11_reg <= '0;
                        stage_c12_reg <= '0;
                        stage_c21_reg <= '0;
                        if (size < 17'sd2) begin
                            state_reg <= FIN;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                            busy      <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    tiles_in_reg <= tiles_in_next;
                    if (take11) begin
                        stage_c11_reg <= c11;
                    end
                    if (take_edge) begin
                        stage_c12_reg <= c12;
                        stage_c21_reg <= c21;
                    end
                    if ((tiles_in_next == expected_reg) && (count_next == '0)) begin
                        state_reg <= FIN;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                FIN: begin
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase

            // Buffer and serializer; the buffer is always empty outside RUN.
            count_reg <= count_next;
            out_valid <= (count_next != '0);
            if (commit) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop_last) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (fire) begin
                word_idx_reg <= word_idx_reg + 2'd1;
            end
            if (load_word) begin
                out_data <= next_word;
            end
        end
    end

`ifdef RESULT_DRAIN_ERR_EN
    logic err_reg;
    logic seen11_reg;
    logic seen_edge_reg;
    logic seq_err;

    always_comb begin
        seq_err = (take22 && !has_slot)
               || (take_edge && !(seen11_reg || take11))
               || (take22 && !(seen_edge_reg || take_edge))
               || (take22 && (tiles_in_next > expected_reg));
    end

    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            err_reg       <= 1'b0;
            seen11_reg    <= 1'b0;
            seen_edge_reg <= 1'b0;
        end else begin
            if (take22) begin
                seen11_reg    <= 1'b0;
                seen_edge_reg <= 1'b0;
            end else begin
                if (take11) begin
                    seen11_reg <= 1'b1;
                end
                if (take_edge) begin
                    seen_edge_reg <= 1'b1;
                end
            end
            if (seq_err) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_result_drain.sv
// Directed testbench for result_drain (TILE_DEPTH = 2). A negedge monitor
// collects accepted words, checks that stalled words are held, and records
// done pulses; the main sequence compares against hand-computed values.
module tb_result_drain;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic signed [16:0] size;
    logic               push11, pushedge, push22;
    logic signed [31:0] c11, c12, c21, c22;
    logic        [31:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               busy, done, err;

`ifdef RESULT_DRAIN_ERR_EN
    localparam logic [31:0] ERR_ON = 32'd1;
`else
    localparam logic [31:0] ERR_ON = 32'd0;
`endif

    result_drain #(.TILE_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .start(start), .size(size),
        .push11(push11), .pushedge(pushedge), .push22(push22),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] got_q[$];
    int          last_acc_cyc, done_cyc, done_count, first_valid_cyc;
    int          push22_cyc, start_cyc, first_p22;
    bit          valid_seen;
    bit          stall_pend = 1'b0;
    logic [31:0] stall_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_data, stall_data);
            end
            stall_pend = out_valid && !out_ready;
            stall_data = out_data;
            if (out_valid) begin
                valid_seen = 1'b1;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                last_acc_cyc = cyc;
                $display("word %0d = %0d at cycle %0d", got_q.size() - 1, out_data, cyc);
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
                $display("done at cycle %0d", cyc);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_job;
        got_q.delete();
        done_count      = 0;
        done_cyc        = -1;
        last_acc_cyc    = -1;
        first_valid_cyc = -1;
        valid_seen      = 1'b0;
    endtask

    task automatic do_start(input int s);
        size      = s[16:0];
        start     = 1'b1;
        start_cyc = cyc;
        tick;
        start     = 1'b0;
        size      = 17'sd0;
    endtask

    task automatic push_tile(input int base, input int gap);
        c11 = base + 1; push11 = 1'b1; tick; push11 = 1'b0;
        c12 = base + 2; c21 = base + 3; pushedge = 1'b1; tick; pushedge = 1'b0;
        c22 = base + 4; push22 = 1'b1; push22_cyc = cyc; tick; push22 = 1'b0;
        repeat (gap) tick;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_count == 0; i++) tick;
        check("done_seen", 32'(done_count), 32'd1);
    endtask

    // Words of tiles 0..n_tiles-1 with base 10000*t: 1,2,3,4 + base.
    task automatic check_words(input string tag, input int n_tiles);
        check({tag, "_count"}, 32'(got_q.size()), 32'(n_tiles * 4));
        for (int i = 0; i < got_q.size() && i < n_tiles * 4; i++) begin
            check($sformatf("%s_word%0d", tag, i), got_q[i], 32'((i / 4) * 10000 + (i % 4) + 1));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; size = 17'sd0;
        push11 = 1'b0; pushedge = 1'b0; push22 = 1'b0;
        c11 = 0; c12 = 0; c21 = 0; c22 = 0;
        out_ready = 1'b0;
        clear_job;
        repeat (3) tick;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        repeat (5) tick;
        check("idle_no_valid", 32'(valid_seen), 32'd0);

        // size 4, four tiles, consumer always ready
        clear_job;
        out_ready = 1'b1;
        do_start(4);
        check("a_busy", 32'(busy), 32'd1);
        for (int t = 0; t < 4; t++) begin
            push_tile(10000 * t, 1);
            if (t == 0) first_p22 = push22_cyc;
        end
        wait_done(100);
        check_words("a", 4);
        check("a_latency", 32'(first_valid_cyc), 32'(first_p22 + 1));
        check("a_done_time", 32'(done_cyc), 32'(last_acc_cyc + 1));
        check("a_err", 32'(err), 32'd0);
        repeat (3) tick;
        check("a_done_width", 32'(done_count), 32'd1);
        check("a_busy_end", 32'(busy), 32'd0);

        // same job with out_ready toggling every cycle
        clear_job;
        out_ready = 1'b0;
        do_start(4);
        fork
            begin
                for (int t = 0; t < 4; t++) push_tile(10000 * t, 6);
            end
            begin
                for (int i = 0; i < 400 && done_count == 0; i++) begin
                    tick;
                    out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        check("b_done_seen", 32'(done_count), 32'd1);
        check_words("b", 4);
        check("b_done_time", 32'(done_cyc), 32'(last_acc_cyc + 1));
        check("b_err", 32'(err), 32'd0);
        repeat (3) tick;

        // overflow: consumer stalled, buffer holds two tiles
        clear_job;
        out_ready = 1'b0;
        do_start(4);
        for (int t = 0; t < 3; t++) push_tile(10000 * t, 1);
        check("c_err_drop", 32'(err), ERR_ON);
        push_tile(30000, 1);
        out_ready = 1'b1;
        wait_done(100);
        check_words("c", 2);
        check("c_done_time", 32'(done_cyc), 32'(last_acc_cyc + 1));
        repeat (3) tick;
        check("c_done_width", 32'(done_count), 32'd1);

        // size 1: FIN right after start, no output words
        clear_job;
        do_start(1);
        repeat (3) tick;
        check("d_done_count", 32'(done_count), 32'd1);
        check("d_done_time", 32'(done_cyc), 32'(start_cyc + 1));
        check("d_no_valid", 32'(valid_seen), 32'd0);
        check("d_busy", 32'(busy), 32'd0);

        // pushedge without push11
        clear_job;
        do_start(4);
        pushedge = 1'b1; tick; pushedge = 1'b0; tick;
        check("e_err_seq", 32'(err), ERR_ON);
        reset = 1'b1; tick; reset = 1'b0;
        check("e_err_cleared", 32'(err), 32'd0);
        check("e_busy_cleared", 32'(busy), 32'd0);

        // reset in the middle of a tile
        clear_job;
        out_ready = 1'b1;
        do_start(4);
        push_tile(50000, 0);
        for (int i = 0; i < 20 && got_q.size() < 2; i++) tick;
        reset = 1'b1; tick; reset = 1'b0;
        check("f_words", 32'(got_q.size()), 32'd2);
        check("f_word0", got_q.size() > 0 ? got_q[0] : 32'hFFFF_FFFF, 32'd50001);
        check("f_word1", got_q.size() > 1 ? got_q[1] : 32'hFFFF_FFFF, 32'd50002);
        check("f_valid", 32'(out_valid), 32'd0);
        check("f_busy", 32'(busy), 32'd0);
        check("f_done", 32'(done), 32'd0);
        clear_job;
        repeat (4) tick;
        check("f_discarded", 32'(valid_seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
